kanagawa_dsp_mul_arbiter: RTL

//  Shares one pipelined 18x18 DSP multiplier between NUM_REQ requesters. Each cycle a round-robin

---
 rtl/kanagawa_dsp_pkg.sv | 38 +++
 rtl/kanagawa_dsp_mul_pipe.sv | 38 +++
 rtl/kanagawa_dsp_mul_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/kanagawa_dsp_pkg.sv
// Shared constants, tag payload and round-robin pick helper for the DSP multiplier arbiter.
package kanagawa_dsp_pkg;

   localparam int unsigned DSP_OP_W        = 18;
   localparam int unsigned DSP_RES_W       = 36;
   localparam int unsigned DSP_MUL_LATENCY = 2;
   localparam int unsigned DSP_MAX_REQ     = 16;
   localparam int unsigned DSP_ID_MAX_W    = 4;

   // Tag id is sized for the largest requester count; users truncate to their own ID_W.
   typedef struct packed {
      logic                    v;
      logic [DSP_ID_MAX_W-1:0] id;
   } dsp_tag_t;

   // One-hot grant: first valid index at or after ptr, wrapping at n-1 -> 0.
   function automatic logic [DSP_MAX_REQ-1:0] rr_pick(input logic [DSP_MAX_REQ-1:0]  valid,
                                                     input logic [DSP_ID_MAX_W-1:0] ptr,
                                                     input int unsigned             n);
      logic [DSP_MAX_REQ-1:0] grant;
      logic                   found;
      int unsigned            idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < DSP_MAX_REQ; k++) begin
         if (k < n) begin
            idx = 32'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (!found && valid[4'(idx)]) begin
               grant[4'(idx)] = 1'b1;
               found          = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/kanagawa_dsp_mul_pipe.sv
// Two-stage 18x18 multiplier: operand registers, then product register; maps onto one DSP block.
(* use_dsp = "yes" *)
module kanagawa_dsp_mul_pipe
   import kanagawa_dsp_pkg::*;
#(
   parameter bit SIGNED = 1'b0
) (
   input  logic                 clk,
   input  logic [DSP_OP_W-1:0]  x,
   input  logic [DSP_OP_W-1:0]  y,
   output logic [DSP_RES_W-1:0] product
);

   logic [DSP_OP_W-1:0]  x_q, y_q;
   logic [DSP_RES_W-1:0] product_q, product_d;
   logic [DSP_RES_W-1:0] x_ext, y_ext;

   // Extend to the full result width first so the 36-bit product is exact in both modes.
   always_comb begin
      x_ext = {{(DSP_RES_W-DSP_OP_W){1'b0}}, x_q};
      y_ext = {{(DSP_RES_W-DSP_OP_W){1'b0}}, y_q};
      if (SIGNED) begin
         x_ext = {{(DSP_RES_W-DSP_OP_W){x_q[DSP_OP_W-1]}}, x_q};
         y_ext = {{(DSP_RES_W-DSP_OP_W){y_q[DSP_OP_W-1]}}, y_q};
      end
      product_d = DSP_RES_W'(x_ext * y_ext);
   end

   // Datapath registers carry no reset so they pack into the DSP pipeline registers.
   always_ff @(posedge clk) begin
      x_q       <= x;
      y_q       <= y;
      product_q <= product_d;
   end

   assign product = product_q;

endmodule

// File: rtl/kanagawa_dsp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 18x18 multiplier among NUM_REQ requesters;
// results return tagged to their owner two cycles after the grant.
module kanagawa_dsp_mul_arbiter
   import kanagawa_dsp_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter bit          SIGNED  = 1'b0,
   parameter int unsigned LATENCY = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   input  logic [NUM_REQ*DSP_OP_W-1:0]     req_x_in,
   input  logic [NUM_REQ*DSP_OP_W-1:0]     req_y_in,
   output logic [NUM_REQ-1:0]              req_ready_out,
   output logic [NUM_REQ-1:0]              rsp_valid_out,
   output logic [$clog2(NUM_REQ)-1:0]      rsp_id_out,
   output logic [DSP_RES_W-1:0]            rsp_result_out,
   output logic                            busy_out
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   if (LATENCY != DSP_MUL_LATENCY) begin : g_bad_latency
      $fatal(1, "kanagawa_dsp_mul_arbiter: LATENCY must be 2");
   end
   if (NUM_REQ < 2 || NUM_REQ > DSP_MAX_REQ) begin : g_bad_num_req
      $fatal(1, "kanagawa_dsp_mul_arbiter: NUM_REQ must be 2..16");
   end

   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   dsp_tag_t             tag0_q, tag0_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
   logic                 busy_q, busy_d;

   logic [NUM_REQ-1:0]   grant_c;
   logic [ID_W-1:0]      grant_idx;
   logic [DSP_OP_W-1:0]  x_mux, y_mux;
   logic [DSP_RES_W-1:0] product;

   // Arbitration, operand mux and next-state for pointer and tag pipeline.
   always_comb begin
      grant_c     = NUM_REQ'(rr_pick(DSP_MAX_REQ'(req_valid_in), DSP_ID_MAX_W'(rr_ptr_q), NUM_REQ));
      grant_idx   = '0;
      x_mux       = '0;
      y_mux       = '0;
      rr_ptr_d    = rr_ptr_q;
      tag0_d      = '0;
      rsp_valid_d = '0;
      rsp_id_d    = ID_W'(tag0_q.id);
      busy_d      = 1'b0;

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            grant_idx = ID_W'(i);
            x_mux     = req_x_in[DSP_OP_W*i +: DSP_OP_W];
            y_mux     = req_y_in[DSP_OP_W*i +: DSP_OP_W];
         end
      end

      if (|grant_c) begin
         rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         tag0_d.v  = 1'b1;
         tag0_d.id = DSP_ID_MAX_W'(grant_idx);
      end

      if (tag0_q.v) rsp_valid_d[ID_W'(tag0_q.id)] = 1'b1;

      // After the edge, S0 holds this cycle's grant and S1 holds the current S0 tag.
      busy_d = tag0_d.v | tag0_q.v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         tag0_q      <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         tag0_q      <= tag0_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         busy_q      <= busy_d;
      end
   end

   kanagawa_dsp_mul_pipe #(
      .SIGNED (SIGNED)
   ) u_mul_pipe (
      .clk     (clk),
      .x       (x_mux),
      .y       (y_mux),
      .product (product)
   );

   // Product register is unreset; gating by the strobe keeps the result port clean out of reset.
   always_comb begin
      req_ready_out  = grant_c;
      rsp_valid_out  = rsp_valid_q;
      rsp_id_out     = rsp_id_q;
      busy_out       = busy_q;
      rsp_result_out = (|rsp_valid_q) ? product : '0;
   end

endmodule
